crc_frame_rx: RTL and testbench

CRC_FRAME_RX -- requirements
Module: crc_frame_rx

---
 rtl/crc_pkg.sv | 15 +
 rtl/crc_serial_core.sv | 36 +++
 rtl/crc_frame_rx.sv | 133 +++++++++++++
 tb/tb_crc_frame_rx.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared CRC definitions: receiver FSM state encoding and default generator/seed.
// Used by the serial CRC core and by frame-level generator/verifier blocks.
package crc_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // x^4 + x + 1 with the implicit MSB written out; seed of all zeros.
    localparam logic [4:0] POLY_DEF = 5'b10011;
    localparam logic [3:0] SEED_DEF = 4'b0000;

endpackage

// File: rtl/crc_serial_core.sv
// Bit-serial MSB-first CRC register (Galois form) with synchronous clear to SEED.
// Holds its value whenever enable is low, so the residue can be read after the last bit.
module crc_serial_core #(
    parameter int                   CRC_WIDTH = 4,
    parameter logic [CRC_WIDTH:0]   POLY      = crc_pkg::POLY_DEF,
    parameter logic [CRC_WIDTH-1:0] SEED      = crc_pkg::SEED_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 bit_in,
    output logic [CRC_WIDTH-1:0] crc
);

    logic [CRC_WIDTH-1:0] r_crc;
    logic                 w_fb;
    logic [CRC_WIDTH-1:0] w_crc_next;

    assign w_fb       = bit_in ^ r_crc[CRC_WIDTH-1];
    assign w_crc_next = (r_crc << 1) ^ (w_fb ? POLY[CRC_WIDTH-1:0] : '0);

    // clear wins over enable so an aborting frame_start reseeds cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= SEED;
        end else if (clear) begin
            r_crc <= SEED;
        end else if (enable) begin
            r_crc <= w_crc_next;
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/crc_frame_rx.sv
// Serial frame receiver: payload then CRC, MSB first; result held until out_ready.
// Optional error counter enabled by defining CRC_FRAME_RX_ERR_CNT_EN.
module crc_frame_rx
    import crc_pkg::*;
#(
    parameter int                   DATA_WIDTH = 12,
    parameter int                   CRC_WIDTH  = 4,
    parameter logic [CRC_WIDTH:0]   POLY       = POLY_DEF,
    parameter logic [CRC_WIDTH-1:0] SEED       = SEED_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  crc_ok,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  rx_drop,
    output logic [1:0]            o_dbg_state
`ifdef CRC_FRAME_RX_ERR_CNT_EN
    ,
    output logic [7:0]            err_count
`endif
);

    localparam int FRAME_BITS = DATA_WIDTH + CRC_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    state_t                  r_state, w_state_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [FRAME_BITS-1:0]   r_shift;
    logic                    r_drop;
    logic [CRC_WIDTH-1:0]    w_crc;
    logic                    w_init;
    logic                    w_accept;
    logic                    w_drop;

    crc_serial_core #(
        .CRC_WIDTH (CRC_WIDTH),
        .POLY      (POLY),
        .SEED      (SEED)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_init),
        .enable (w_accept),
        .bit_in (bit_in),
        .crc    (w_crc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // frame_start always outranks bit_valid; the counter guard keeps it from wrapping.
    always_comb begin
        w_state_next = r_state;
        w_init       = 1'b0;
        w_accept     = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_init       = 1'b1;
                    w_state_next = S_RECV;
                end
            end
            S_RECV: begin
                if (frame_start) begin
                    w_init = 1'b1;
                    w_drop = 1'b1;
                end else if (bit_valid && r_cnt != '0) begin
                    w_accept = 1'b1;
                    if (r_cnt == CNT_W'(1)) w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                w_drop = frame_start | bit_valid;
                if (out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= w_drop;
            if (w_init) begin
                r_cnt   <= CNT_W'(FRAME_BITS);
                r_shift <= '0;
            end else if (w_accept) begin
                r_cnt   <= r_cnt - CNT_W'(1);
                r_shift <= {r_shift[FRAME_BITS-2:0], bit_in};
            end
        end
    end

    // Shift register and CRC are frozen in S_HOLD, so outputs stay stable there.
    assign out_valid   = (r_state == S_HOLD);
    assign busy        = (r_state != S_IDLE);
    assign data_out    = r_shift[FRAME_BITS-1:CRC_WIDTH];
    assign crc_ok      = out_valid && (w_crc == '0);
    assign rx_drop     = r_drop;
    assign o_dbg_state = r_state;

`ifdef CRC_FRAME_RX_ERR_CNT_EN
    logic       r_was_hold;
    logic [7:0] r_err_count;

    // Counts a bad frame on the first cycle of S_HOLD, when the residue is final.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_was_hold  <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_was_hold <= out_valid;
            if (out_valid && !r_was_hold && !crc_ok && r_err_count != 8'hFF)
                r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_crc_frame_rx.sv
// Directed bench for crc_frame_rx at default parameters (12-bit payload, CRC-4 x^4+x+1).
// Define CRC_FRAME_RX_ERR_CNT_EN for both files to exercise the error counter.
module tb_crc_frame_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [11:0] data_out;
    logic        crc_ok;
    logic        out_valid;
    logic        busy;
    logic        rx_drop;
    logic [1:0]  dbg_state;
`ifdef CRC_FRAME_RX_ERR_CNT_EN
    logic [7:0]  err_count;
    int          exp_err = 0;
`endif

    int checks = 0;
    int errors = 0;
    int drop_cnt = 0;
    int hs_cnt = 0;

    crc_frame_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .data_out    (data_out),
        .crc_ok      (crc_ok),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .rx_drop     (rx_drop),
        .o_dbg_state (dbg_state)
`ifdef CRC_FRAME_RX_ERR_CNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_drop) drop_cnt++;
        if (out_valid && out_ready) hs_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic with_bit);
        frame_start = 1'b1;
        bit_valid   = with_bit;
        bit_in      = 1'b1;
        tick();
        frame_start = 1'b0;
        bit_valid   = 1'b0;
    endtask

    // Sends word bits [15-first] downward, n of them; no gap after the final bit.
    task automatic send_bits(input logic [15:0] word, input int first, input int n, input bit gapped);
        for (int i = first; i < first + n; i++) begin
            bit_valid = 1'b1;
            bit_in    = word[15-i];
            tick();
            bit_valid = 1'b0;
            if (gapped && i != first + n - 1) tick();
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || rx_drop !== 1'b0 || crc_ok !== 1'b0) begin
            $display("FAIL reset_ctrl: valid=%b busy=%b drop=%b ok=%b, required all 0", out_valid, busy, rx_drop, crc_ok);
            errors++;
        end
        checks++;
        if (data_out !== 12'h000 || dbg_state !== 2'd0) begin
            $display("FAIL reset_data: data=%h state=%0d, required 000/0", data_out, dbg_state);
            errors++;
        end
`ifdef CRC_FRAME_RX_ERR_CNT_EN
        checks++;
        if (err_count !== 8'd0) begin
            $display("FAIL reset_err_count: got %0d, required 0", err_count);
            errors++;
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_idle_ignore();
        int d0;
        d0 = drop_cnt;
        send_bits(16'hFFFF, 0, 4, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || drop_cnt != d0) begin
            $display("FAIL idle_ignore: busy=%b valid=%b drops=%0d, required 0/0/0", busy, out_valid, drop_cnt - d0);
            errors++;
        end
    endtask

    task automatic test_good();
        start_frame(1'b1);
        checks++;
        if (busy !== 1'b1 || dbg_state !== 2'd1) begin
            $display("FAIL good_busy: busy=%b state=%0d, required 1/1", busy, dbg_state);
            errors++;
        end
        send_bits(16'hABCA, 0, 15, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL good_early_valid: got %b, required 0", out_valid);
            errors++;
        end
        send_bits(16'hABCA, 15, 1, 0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 12'hABC || crc_ok !== 1'b1) begin
            $display("FAIL good_result: valid=%b data=%h ok=%b, required 1/abc/1", out_valid, data_out, crc_ok);
            errors++;
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
            $display("FAIL good_release: valid=%b busy=%b state=%0d, required 0/0/0", out_valid, busy, dbg_state);
            errors++;
        end
    endtask

    task automatic test_corrupt();
        start_frame(1'b0);
        send_bits(16'hABCB, 0, 16, 0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 12'hABC || crc_ok !== 1'b0) begin
            $display("FAIL corrupt_result: valid=%b data=%h ok=%b, required 1/abc/0", out_valid, data_out, crc_ok);
            errors++;
        end
        handshake();
`ifdef CRC_FRAME_RX_ERR_CNT_EN
        exp_err++;
        checks++;
        if (err_count !== 8'(exp_err)) begin
            $display("FAIL corrupt_err_count: got %0d, required %0d", err_count, exp_err);
            errors++;
        end
`endif
    endtask

    task automatic test_gapped();
        start_frame(1'b0);
        send_bits(16'hABCA, 0, 15, 1);
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL gapped_wait: valid=%b busy=%b, required 0/1", out_valid, busy);
            errors++;
        end
        send_bits(16'hABCA, 15, 1, 0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 12'hABC || crc_ok !== 1'b1) begin
            $display("FAIL gapped_result: valid=%b data=%h ok=%b, required 1/abc/1", out_valid, data_out, crc_ok);
            errors++;
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int d0;
        int bad;
        start_frame(1'b0);
        send_bits(16'hABCA, 0, 16, 0);
        d0  = drop_cnt;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            frame_start = (c == 2);
            tick();
            frame_start = 1'b0;
            if (out_valid !== 1'b1 || data_out !== 12'hABC || crc_ok !== 1'b1 || dbg_state !== 2'd2) bad++;
        end
        tick();
        checks++;
        if (bad != 0) begin
            $display("FAIL bp_stable: %0d unstable cycles, required 0", bad);
            errors++;
        end
        checks++;
        if (drop_cnt - d0 != 1) begin
            $display("FAIL bp_drop: %0d pulses, required 1", drop_cnt - d0);
            errors++;
        end
        handshake();
        checks++;
        if (dbg_state !== 2'd0 || out_valid !== 1'b0) begin
            $display("FAIL bp_idle: state=%0d valid=%b, required 0/0", dbg_state, out_valid);
            errors++;
        end
    endtask

    task automatic test_abort();
        int d0;
        int h0;
        d0 = drop_cnt;
        h0 = hs_cnt;
        start_frame(1'b0);
        send_bits(16'h5555, 0, 7, 0);
        start_frame(1'b1);
        send_bits(16'hABCA, 0, 16, 0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 12'hABC || crc_ok !== 1'b1) begin
            $display("FAIL abort_result: valid=%b data=%h ok=%b, required 1/abc/1", out_valid, data_out, crc_ok);
            errors++;
        end
        handshake();
        tick();
        checks++;
        if (drop_cnt - d0 != 1 || hs_cnt - h0 != 1) begin
            $display("FAIL abort_counts: drops=%0d results=%0d, required 1/1", drop_cnt - d0, hs_cnt - h0);
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        int h0;
        start_frame(1'b0);
        send_bits(16'hABCA, 0, 9, 0);
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || rx_drop !== 1'b0 || crc_ok !== 1'b0 || data_out !== 12'h000) begin
            $display("FAIL rmid_outputs: valid=%b busy=%b drop=%b ok=%b data=%h, required all 0",
                     out_valid, busy, rx_drop, crc_ok, data_out);
            errors++;
        end
        tick();
        tick();
        rst_n = 1'b1;
`ifdef CRC_FRAME_RX_ERR_CNT_EN
        exp_err = 0;
`endif
        h0 = hs_cnt;
        send_bits(16'hABCA, 9, 7, 0);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL rmid_no_stale: valid=%b busy=%b, required 0/0", out_valid, busy);
            errors++;
        end
        start_frame(1'b0);
        send_bits(16'hABCA, 0, 16, 0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 12'hABC || crc_ok !== 1'b1) begin
            $display("FAIL rmid_result: valid=%b data=%h ok=%b, required 1/abc/1", out_valid, data_out, crc_ok);
            errors++;
        end
        handshake();
        checks++;
        if (hs_cnt - h0 != 1) begin
            $display("FAIL rmid_count: %0d results, required 1", hs_cnt - h0);
            errors++;
        end
`ifdef CRC_FRAME_RX_ERR_CNT_EN
        checks++;
        if (err_count !== 8'(exp_err)) begin
            $display("FAIL rmid_err_count: got %0d, required %0d", err_count, exp_err);
            errors++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_good();
        test_corrupt();
        test_gapped();
        test_backpressure();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
